// File: rtl/gcd_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_ctrl
// Control unit for a 16-bit subtract/compare datapath. It computes the GCD of
// two operands by repeated subtraction (Euclid's method). The FSM loads both
// operands over the shared AB bus and short-circuits when either operand is
// zero. It then alternates compare and subtract steps until A == B. The host
// sees a start/done handshake, and the datapath output C carries the result.
//
// Parameters:
//   CNT_W     width of the subtraction-step counter
//   MAX_ITER  subtraction steps allowed before the run aborts with err
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   computation request, sampled only in IDLE
//   op_sel   out  operand the host drives onto AB (0 = A, 1 = B)
//   ABorALU  out  datapath register input mux (1 = AB bus, 0 = ALU result)
//   LDA      out  load datapath register A
//   LDB      out  load datapath register B
//   FN       out  ALU function: 00 pass A, 01 pass B, 10 A-B, 11 B-A
//   N        in   ALU result negative
//   Z        in   ALU result zero
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   err      out  valid with done; step limit exceeded
// -----------------------------------------------------------------------------
module gcd_ctrl #(
    parameter int CNT_W    = 17,
    parameter int MAX_ITER = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       op_sel,
    output logic       ABorALU,
    output logic       LDA,
    output logic       LDB,
    output logic [1:0] FN,
    input  logic       N,
    input  logic       Z,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ZCHK_A,
        S_ZCHK_B,
        S_CMP,
        S_SUB_AB,
        S_SUB_BA,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_sel_q, res_sel_d;
    logic             err_q, err_d;

    // State and bookkeeping registers. res_sel and err persist through IDLE,
    // so C keeps showing the last result until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            res_sel_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_sel_q <= res_sel_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_sel_d = res_sel_q;
        err_d     = err_q;

        op_sel  = 1'b0;
        ABorALU = 1'b0;
        LDA     = 1'b0;
        LDB     = 1'b0;
        FN      = 2'b00;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                FN   = res_sel_q ? 2'b01 : 2'b00;
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD_A: begin
                ABorALU = 1'b1;
                LDA     = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                ABorALU = 1'b1;
                LDB     = 1'b1;
                op_sel  = 1'b1;
                state_d = S_ZCHK_A;
            end
            // A == 0 means the GCD is B, which also covers both operands zero.
            S_ZCHK_A: begin
                FN = 2'b00;
                if (Z) begin
                    res_sel_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ZCHK_B;
                end
            end
            S_ZCHK_B: begin
                FN = 2'b01;
                if (Z) begin
                    res_sel_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_CMP;
                end
            end
            // Equality wins over the step limit: a run that converges on its
            // last allowed compare still finishes cleanly.
            S_CMP: begin
                FN = 2'b10;
                if (Z) begin
                    res_sel_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == MAX_CNT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (N) begin
                    state_d = S_SUB_BA;
                end else begin
                    state_d = S_SUB_AB;
                end
            end
            S_SUB_AB: begin
                FN      = 2'b10;
                LDA     = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_CMP;
            end
            S_SUB_BA: begin
                FN      = 2'b11;
                LDB     = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_CMP;
            end
            S_DONE: begin
                FN      = res_sel_q ? 2'b01 : 2'b00;
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gcd_ctrl
// Testbench for gcd_ctrl. It drives two controllers: one with the default step
// limit and one with MAX_ITER = 4. Each controller has its own behavioural
// 16-bit datapath (A/B registers, input mux, ALU with N/Z flags). The bench
// compares completion cycle, err and result against an arithmetic Euclid
// reference.
// -----------------------------------------------------------------------------
module tb_gcd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [15:0] opA, opB;

    logic        opSel   [2];
    logic        abOrAlu [2];
    logic        lda     [2];
    logic        ldb     [2];
    logic [1:0]  fn      [2];
    logic        nFlag   [2];
    logic        zFlag   [2];
    logic        busy    [2];
    logic        done    [2];
    logic        err     [2];
    logic [16:0] aluY    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: 17-bit result so that bit 16 flags a negative difference.
    function automatic logic [16:0] aluFn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'b00:   return {1'b0, a};
            2'b01:   return {1'b0, b};
            2'b10:   return {1'b0, a} - {1'b0, b};
            default: return {1'b0, b} - {1'b0, a};
        endcase
    endfunction

    // One datapath model per controller; the host drives the operand picked by op_sel.
    for (genvar g = 0; g < 2; g++) begin : gDp
        logic [15:0] regA, regB, abBus;
        assign abBus    = opSel[g] ? opB : opA;
        assign aluY[g]  = aluFn(fn[g], regA, regB);
        assign nFlag[g] = aluY[g][16];
        assign zFlag[g] = (aluY[g] == 17'd0);
        always_ff @(posedge clk) begin
            if (lda[g]) regA <= abOrAlu[g] ? abBus : aluY[g][15:0];
            if (ldb[g]) regB <= abOrAlu[g] ? abBus : aluY[g][15:0];
        end
    end

    gcd_ctrl dut0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .op_sel(opSel[0]), .ABorALU(abOrAlu[0]), .LDA(lda[0]), .LDB(ldb[0]),
        .FN(fn[0]), .N(nFlag[0]), .Z(zFlag[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    gcd_ctrl #(.CNT_W(17), .MAX_ITER(4)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .op_sel(opSel[1]), .ABorALU(abOrAlu[1]), .LDA(lda[1]), .LDB(ldb[1]),
        .FN(fn[1]), .N(nFlag[1]), .Z(zFlag[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Reference: Euclid by subtraction on plain integers, with the zero-operand
    // shortcuts and the step limit; returns the cycle (after the start edge) of done.
    function automatic void refGcd(input int a, input int b, input int maxIter,
                                   output int c, output int cyc, output logic e);
        int s = 0;
        e = 1'b0;
        if (a == 0) begin
            c = b; cyc = 4;
        end else if (b == 0) begin
            c = a; cyc = 5;
        end else begin
            while (a != b) begin
                if (s == maxIter) begin
                    e = 1'b1;
                    break;
                end
                if (a > b) a = a - b;
                else       b = b - a;
                s++;
            end
            c   = a;
            cyc = e ? 6 + 2 * maxIter : 6 + 2 * s;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete run on controller inst. With hold set, start stays high, and
    // the bench then checks the automatic relaunch and times the second run.
    task automatic applyStimulus(input int inst, input int a, input int b, input string tag, input bit hold);
        int   expC, expCyc, cyc;
        logic expErr;
        bit   seen;
        refGcd(a, b, inst == 0 ? 65535 : 4, expC, expCyc, expErr);
        opA = 16'(a);
        opB = 16'(b);
        @(negedge clk);
        start[inst] = 1'b1;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < expCyc + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !hold) start[inst] = 1'b0;
            if (cyc == 1) begin
                checkOutput({tag, ":loadA"}, {lda[inst], abOrAlu[inst], opSel[inst]}, 3'b110);
            end
            if (cyc == 2) begin
                checkOutput({tag, ":loadB"}, {ldb[inst], abOrAlu[inst], opSel[inst]}, 3'b111);
            end
            // A stray start pulse while busy must not disturb the run.
            if (cyc == 3 && expCyc >= 5 && !hold) start[inst] = 1'b1;
            if (cyc == 4 && !hold) start[inst] = 1'b0;
            if (done[inst]) seen = 1;
            else            checkOutput({tag, ":busy"}, busy[inst], 1'b1);
        end
        checkOutput({tag, ":done"}, done[inst], 1'b1);
        checkOutput({tag, ":cycles"}, cyc, expCyc);
        checkOutput({tag, ":err"}, err[inst], expErr);
        if (!expErr) checkOutput({tag, ":result"}, aluY[inst][15:0], expC);
        @(negedge clk);
        checkOutput({tag, ":donePulse"}, {done[inst], busy[inst]}, 2'b00);
        if (!expErr) begin
            checkOutput({tag, ":idleResult"}, aluY[inst][15:0], expC);
            checkOutput({tag, ":idleFn"}, fn[inst], (a == 0) ? 2'b01 : 2'b00);
        end
        if (hold) begin
            @(negedge clk);
            checkOutput({tag, ":relaunch"}, {busy[inst], lda[inst]}, 2'b11);
            start[inst] = 1'b0;
            cyc  = 1;
            seen = 0;
            while (!seen && cyc < expCyc + 20) begin
                @(negedge clk);
                cyc++;
                if (done[inst]) seen = 1;
            end
            checkOutput({tag, ":reDone"}, done[inst], 1'b1);
            checkOutput({tag, ":reCycles"}, cyc, expCyc);
            if (!expErr) checkOutput({tag, ":reResult"}, aluY[inst][15:0], expC);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 2'b00;
        opA   = '0;
        opB   = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs",
                    {opSel[0], abOrAlu[0], lda[0], ldb[0], fn[0], busy[0], done[0], err[0]}, 9'd0);
        checkOutput("resetOutputs1",
                    {opSel[1], abOrAlu[1], lda[1], ldb[1], fn[1], busy[1], done[1], err[1]}, 9'd0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(0, 12, 8, "a12b8", 0);
        applyStimulus(0, 0, 9, "aZero", 0);
        applyStimulus(0, 7, 0, "bZero", 0);
        applyStimulus(0, 0, 0, "bothZero", 0);
        applyStimulus(0, 65535, 65535, "maxEqual", 0);
        applyStimulus(0, 1, 2000, "longRun", 0);
        applyStimulus(0, 48, 18, "a48b18", 0);

        // Reset in the middle of the first SUB_AB (cycle 6 for A=100, B=3).
        opA = 16'd100;
        opB = 16'd3;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("preAbortSub", {lda[0], fn[0]}, 3'b110);
        reset = 1'b0;
        #1;
        checkOutput("abortOutputs",
                    {opSel[0], abOrAlu[0], lda[0], ldb[0], fn[0], busy[0], done[0], err[0]}, 9'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abortStaysIdle", busy[0], 1'b0);
        end

        applyStimulus(1, 100, 1, "iterLimit", 0);
        applyStimulus(1, 9, 6, "afterLimit", 0);
        applyStimulus(0, 12, 8, "holdStart", 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, int'($urandom_range(0, 300)), int'($urandom_range(0, 300)), "rand0", 0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), "rand1", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
